// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives all 16 input vectors of a 4-input combinational circuit
//               under test, holds each for SETTLE_CYCLES cycles, samples the
//               response f, and reports the captured truth table, its ones
//               count and whether it equals a reference table.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones,
    output logic        match
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Settle counter value on which the vector is considered stable
    localparam logic [3:0] C_LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [3:0]  r_vec;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_table;
    logic [4:0]  r_ones;
    logic        r_match;

    // Sweep sequencer: every output is a register so the circuit under test
    // and downstream logic see glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_vec   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= 16'd0;
            r_ones  <= 5'd0;
            r_match <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Results of the previous sweep persist until a new start
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_idx   <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_vec   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_table <= 16'd0;
                        r_ones  <= 5'd0;
                        r_match <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == C_LAST_SETTLE) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_table[r_idx] <= f;
                    r_ones         <= r_ones + {4'd0, f};
                    if (r_idx == 4'd15) begin
                        // Vector 15 is the last one; never wrap mid-sweep
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SETTLE;
                        r_idx   <= r_idx + 4'd1;
                        r_vec   <= r_idx + 4'd1;
                        r_cnt   <= 4'd0;
                    end
                end
                S_DONE: begin
                    // Reference table is only looked at here
                    r_match <= (r_table == expected);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_vec   <= 4'd0;
                    r_idx   <= 4'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // a is the MSB of the applied vector
    assign {a, b, c, d} = r_vec;
    assign busy         = r_busy;
    assign done         = r_done;
    assign table_out    = r_table;
    assign ones         = r_ones;
    assign match        = r_match;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Scoreboard bench for truth_table_sweeper. Stimulus pushes the
//               expected result of each sweep; monitors pop and compare on
//               every done pulse. A second instance runs with SETTLE_CYCLES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    typedef struct {
        int unsigned cyc;
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        match;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start, start2;
    logic        f, f2;
    logic [15:0] expected, expected2;
    logic        a, b, c, d, busy, done, match;
    logic        a2, b2, c2, d2, busy2, done2, match2;
    logic [15:0] table_out, table_out2;
    logic [4:0]  ones, ones2;

    int          mode;
    int unsigned cyc;
    int          n_pass;
    int          n_total;
    exp_t        q[$];
    exp_t        q2[$];

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f(f), .expected(expected),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
        .table_out(table_out), .ones(ones), .match(match)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .f(f2), .expected(expected2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
        .table_out(table_out2), .ones(ones2), .match(match2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    // Models of the circuits under test
    always_comb begin
        f = 1'b0;
        case (mode)
            1:       f = 1'b1;
            2:       f = (a ^ b) & (c | ~d);
            default: f = 1'b0;
        endcase
    end
    assign f2 = a2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        else
            n_pass++;
    endtask

    // Monitors: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("table_out", {16'd0, table_out}, {16'd0, e.tbl});
                chk("ones", {27'd0, ones}, {27'd0, e.ones});
                chk("match", {31'd0, match}, {31'd0, e.match});
            end
        end
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("done2_cycle", cyc, e.cyc);
                chk("table_out2", {16'd0, table_out2}, {16'd0, e.tbl});
                chk("ones2", {27'd0, ones2}, {27'd0, e.ones});
                chk("match2", {31'd0, match2}, {31'd0, e.match});
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    // Pulse start for one edge; optionally queue the expected sweep result
    task automatic issue(input int m, input logic [15:0] ev, input bit push,
                         input logic [15:0] tbl, input logic [4:0] on, input logic mt,
                         output int unsigned acc);
        exp_t e;
        @(negedge clk);
        mode = m;
        expected = ev;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
        if (push) begin
            e.cyc = acc + 49; e.tbl = tbl; e.ones = on; e.match = mt;
            q.push_back(e);
        end
    endtask

    task automatic drain(input bit second);
        for (int i = 0; i < 300; i++) begin
            if ((second ? q2.size() : q.size()) == 0) break;
            @(negedge clk);
        end
        chk(second ? "drain2" : "drain", second ? q2.size() : q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned acc;
        exp_t e;
        n_pass = 0; n_total = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
        expected = 16'd0; expected2 = 16'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {4'd0, a, b, c, d, busy, done, table_out, ones, match}, 0);
        chk("reset_outputs2", {4'd0, a2, b2, c2, d2, busy2, done2, table_out2, ones2, match2}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // f tied 0, reference all zero
        issue(0, 16'h0000, 1'b1, 16'h0000, 5'd0, 1'b1, acc);
        chk("busy_after_start", {31'd0, busy}, 1);
        drain(1'b0);

        // f tied 1, reference differs in bit 0; then results must hold in IDLE
        issue(1, 16'hFFFE, 1'b1, 16'hFFFF, 5'd16, 1'b0, acc);
        drain(1'b0);
        repeat (5) @(negedge clk);
        chk("hold_idle", {6'd0, a, b, c, d, busy, table_out, ones, match}, {6'd0, 4'd0, 1'b0, 16'hFFFF, 5'd16, 1'b0});

        // (a^b)&(c|~d) with vector stepping checks
        issue(2, 16'h0DD0, 1'b1, 16'h0DD0, 5'd6, 1'b1, acc);
        chk("vec_first", {28'd0, a, b, c, d}, 0);
        wait_cyc(acc + 2);
        chk("vec0_held", {28'd0, a, b, c, d}, 0);
        wait_cyc(acc + 3);
        chk("vec1", {28'd0, a, b, c, d}, 1);
        wait_cyc(acc + 47);
        chk("vec15", {28'd0, a, b, c, d}, 15);
        drain(1'b0);
        chk("vec_idle", {28'd0, a, b, c, d}, 0);

        // start re-pulsed while busy, reference disturbed outside DONE
        issue(2, 16'h0DD0, 1'b1, 16'h0DD0, 5'd6, 1'b1, acc);
        wait_cyc(acc + 10); start = 1'b1;
        wait_cyc(acc + 11); start = 1'b0;
        chk("busy_mid", {31'd0, busy}, 1);
        wait_cyc(acc + 20); expected = 16'h0000;
        wait_cyc(acc + 30); start = 1'b1;
        wait_cyc(acc + 31); start = 1'b0;
        wait_cyc(acc + 40); expected = 16'h0DD0;
        drain(1'b0);
        repeat (20) @(negedge clk);
        chk("no_restart", {31'd0, busy}, 0);

        // asynchronous reset mid-sweep aborts without done
        issue(2, 16'h0DD0, 1'b0, 16'h0, 5'd0, 1'b0, acc);
        wait_cyc(acc + 20);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {4'd0, a, b, c, d, busy, done, table_out, ones, match}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("idle_after_reset", {31'd0, busy}, 0);
        issue(1, 16'hFFFF, 1'b1, 16'hFFFF, 5'd16, 1'b1, acc);
        drain(1'b0);

        // SETTLE_CYCLES=1 instance with start held high: back-to-back sweeps
        @(negedge clk);
        expected2 = 16'hFF00;
        start2 = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        e.tbl = 16'hFF00; e.ones = 5'd8; e.match = 1'b1;
        e.cyc = acc + 33; q2.push_back(e);
        e.cyc = acc + 67; q2.push_back(e);
        wait_cyc(acc + 34);
        chk("table_cleared2", {15'd0, busy2, table_out2}, {15'd0, 1'b1, 16'h0000});
        wait_cyc(acc + 67);
        start2 = 1'b0;
        drain(1'b1);
        repeat (3) @(negedge clk);
        chk("idle2", {31'd0, busy2}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
